// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with byte-masked writes and a sticky
// protocol checker that records the first error cause.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp,
  output logic        error,
  output logic [2:0]  err_code
);

  // state | meaning
  // IDLE  | waiting for read|write; accepts and captures a request
  // BUSY  | latency countdown on the captured request
  // RESP  | one-cycle completion pulse; write lanes commit at its closing edge
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = $clog2(LATENCY + 1);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_wmask;
  logic          c_read;
  logic          c_write;
  logic          c_inrange;
  logic [IW-1:0] c_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0] off_live;
  logic        req;
  logic [2:0]  cause;

  assign off_live = addr - BASE_ADDR;
  assign req      = read | write;

  always_comb begin
    cause = 3'd0;
    if (state == IDLE) begin
      if (read && write)             cause = 3'd1;
      else if (req && addr[1:0] != 2'b00) cause = 3'd2;
      else if (req && off_live >= SPAN)   cause = 3'd3;
    end else begin
      if (req && ({addr, read, write, wmask, wdata} !=
                  {c_addr, c_read, c_write, c_wmask, c_wdata}))
        cause = 3'd4;
      else if (state == BUSY && !req)
        cause = 3'd5;
    end
  end

  assign resp  = (state == RESP);
  // Both-high requests are answered as reads, so c_read alone selects read data.
  assign rdata = (state == RESP && c_read && c_inrange) ? mem[c_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      c_addr    <= '0;
      c_wdata   <= '0;
      c_wmask   <= '0;
      c_read    <= 1'b0;
      c_write   <= 1'b0;
      c_inrange <= 1'b0;
      c_idx     <= '0;
      error     <= 1'b0;
      err_code  <= 3'd0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
    end else begin
      if (cause != 3'd0 && err_code == 3'd0) begin
        error    <= 1'b1;
        err_code <= cause;
      end
      case (state)
        IDLE: begin
          if (req) begin
            c_addr    <= addr;
            c_wdata   <= wdata;
            c_wmask   <= wmask;
            c_read    <= read;
            c_write   <= write;
            c_inrange <= (off_live < SPAN);
            c_idx     <= off_live[IW+1:2];
            cnt       <= CW'(LATENCY - 1);
            state     <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= RESP;
        end
        RESP: begin
          if (c_write && !c_read && c_inrange) begin
            for (int b = 0; b < 4; b++)
              if (c_wmask[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable responder for the team's single-outstanding-request word memory handshake (addr/read/write/wmask/wdata in; rdata/resp out).
- Plays the memory side for a DUT-side initiator: fixed-latency backing store with byte-masked writes.
- Built-in protocol checker raises a sticky error with a first-cause code.
- Used in the testbench in place of the behavioural memory, and as on-chip scratch RAM in FPGA builds.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two, >= 2)
LATENCY, 4, cycles from request acceptance to resp (>= 1)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
addr  in  32  byte address of request
read  in  1  read request level
write  in  1  write request level
wmask  in  4  byte enables for write; bit i covers wdata[8i+7:8i]
wdata  in  32  write data
rdata  out  32  read data, valid only while resp=1
resp  out  1  one-cycle completion pulse
error  out  1  sticky protocol/address error flag
err_code  out  3  cause of first error: 0 none, 1 read&write both high, 2 misaligned addr, 3 out of range, 4 request changed while pending, 5 request dropped before resp

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: resp=0, rdata=0, error=0, err_code=0, FSM=IDLE, latency counter=0, all array words cleared to 0. Reset mid-transaction abandons it; no resp is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - When read|write=1 at an edge, capture addr/read/write/wmask/wdata and go to BUSY with cnt=LATENCY-1.
  - If LATENCY=1, go directly to RESP.
- BUSY:
  - Decrement cnt each cycle; go to RESP when cnt reaches 0.
  - Net result: a request first seen at edge T gets resp=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- RESP:
  - resp=1 for exactly one cycle, then IDLE.
  - Read: rdata = array[idx]. Write: array[idx] byte lanes with wmask=1 are updated at the edge ending the RESP cycle.
  - A write and a following read to the same word return the new data.
- Back-to-back: the cycle after RESP is IDLE. If read/write is still high, it is a new request. Minimum spacing between resps is LATENCY+1 cycles.
- rdata=0 whenever resp=0, and also on write responses.
- Index: idx = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- Error checks are evaluated on captured or live inputs. Each sets error=1 and latches err_code, but only if err_code is still 0 (first cause wins). Once set, error stays high until rst.
  - Code 1: read and write both high at acceptance. The request is still answered, treated as a read.
  - Code 2: addr[1:0] != 0 at acceptance. addr[1:0] is ignored for indexing.
  - Code 3: out-of-range address. The request is still answered: resp pulses, rdata=0, the write is dropped.
  - Code 4: in BUSY or RESP, live addr/read/write/wmask/wdata differ from the captured values while read|write=1.
  - Code 5: in BUSY, read and write both 0 before resp. The transaction still completes with the captured values.
- Errors never stall or suppress resp; the FSM always completes.
- wmask=4'b0000 write: resp pulses, array unchanged, no error.
- Counter width: $clog2(LATENCY+1) bits. No wrap is possible.

Test Plan:
- Write/readback: LATENCY=4. Write addr=0x10, wdata=0xDEADBEEF, wmask=4'hF at edge T → resp=1 exactly 4 cycles later. Then read addr=0x10 → resp 4 cycles after acceptance with rdata=0xDEADBEEF, error=0.
- Byte masks: word 0x20 holds 0x11223344. Write wdata=0xAABBCCDD, wmask=4'b0101 → a later read returns 0x11BB33DD. A wmask=0 write leaves the word unchanged.
- Back-to-back: read held high through resp for three consecutive reads at 0x0/0x4/0x8 → resps spaced exactly LATENCY+1=5 cycles apart, with correct data each time.
- Errors:
  - read=write=1 at addr=0x0 → resp pulses, error=1, err_code=1.
  - A subsequent misaligned read at 0x3 keeps err_code=1.
  - After rst: read 0x400 with DEPTH_WORDS=256 → resp, rdata=0, err_code=3.
- Pending violation: change addr from 0x10 to 0x14 two cycles after acceptance → err_code=4, resp still after LATENCY cycles with data from 0x10.
- Reset mid-op: assert rst in BUSY → no resp follows, all outputs 0, and the array reads back 0 at previously written addresses.
